// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard controller: EX operand-forward
// selects and multicycle-execute FSM states.
package pipe_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_WB = 2'b01,
    FWD_ME = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && !(&cnt_q))  cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state flops use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the FE/DE/EX/ME/WB pipeline:
// drives every inter-stage enable/clear plus EX forward selects.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_de,
  input  logic [REG_AW-1:0] rs2_de,
  input  logic              rs1_used_de,
  input  logic              rs2_used_de,
  input  logic [REG_AW-1:0] rs1_ex,
  input  logic [REG_AW-1:0] rs2_ex,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              RuWr_ex,
  input  logic              is_load_ex,
  input  logic              mc_start_ex,
  input  logic [REG_AW-1:0] rd_me,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              RuWr_me,
  input  logic              RuWr_wb,
  input  logic              NextPCSrc,
  input  logic              cnt_clr,
  output logic              en_pc_fe,
  output logic              en_fd,
  output logic              en_de,
  output logic              flush_fd,
  output logic              flush_de,
  output logic              flush_em,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              ex_hold,
  output logic              mc_done,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int  LOAD     = (MC_LAT > 1) ? MC_LAT - 2 : 0;
  localparam int  CW       = $clog2(LOAD + 2);
  localparam bit  MC_MULTI = (MC_LAT > 1);

  mc_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          mc_done_q;

  logic mc_launch, mc_stall, redirect;
  logic raw_ex, raw_me, raw_stall;

  assign mc_launch = MC_MULTI && (state_q == IDLE) && mc_start_ex && !NextPCSrc;
  assign mc_stall  = (state_q == BUSY) || mc_launch;
  assign redirect  = rst_n && !mc_stall && NextPCSrc;

  // mc_done_q is set one edge ahead so it is high exactly in the cnt==0 cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mc_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (mc_launch) begin
          state_q   <= BUSY;
          cnt_q     <= CW'(LOAD);
          mc_done_q <= (LOAD == 0);
        end
        BUSY: if (mc_done_q) begin
          state_q   <= IDLE;
          mc_done_q <= 1'b0;
        end else begin
          cnt_q     <= cnt_q - 1'b1;
          mc_done_q <= (cnt_q == CW'(1));
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign raw_ex = RuWr_ex && (rd_ex != '0) &&
                  ((rs1_used_de && (rs1_de == rd_ex)) || (rs2_used_de && (rs2_de == rd_ex)));
  assign raw_me = RuWr_me && (rd_me != '0) &&
                  ((rs1_used_de && (rs1_de == rd_me)) || (rs2_used_de && (rs2_de == rd_me)));
  // Without forwarding any in-flight EX/ME producer must drain; WB writes before RF read.
  assign raw_stall = FWD_EN ? (raw_ex && is_load_ex) : (raw_ex || raw_me);

  // NOTE: every output gets a default first so no path through the
  // priority chain leaves one unassigned and infers a latch.
  always_comb begin
    en_pc_fe = 1'b1;
    en_fd    = 1'b1;
    en_de    = 1'b1;
    flush_fd = 1'b0;
    flush_de = 1'b0;
    flush_em = 1'b0;
    ex_hold  = 1'b0;
    if (!rst_n) begin
      en_pc_fe = 1'b0;
      en_fd    = 1'b0;
      en_de    = 1'b0;
      flush_fd = 1'b1;
      flush_de = 1'b1;
      flush_em = 1'b1;
    end else if (mc_stall) begin
      en_pc_fe = 1'b0;
      en_fd    = 1'b0;
      en_de    = 1'b0;
      flush_em = 1'b1;
      ex_hold  = mc_launch || !mc_done_q;
    end else if (redirect) begin
      flush_fd = 1'b1;
      flush_de = 1'b1;
    end else if (raw_stall) begin
      en_pc_fe = 1'b0;
      en_fd    = 1'b0;
      flush_de = 1'b1;
    end
  end

  function automatic fwd_sel_e fwd_pick(input logic [REG_AW-1:0] rs);
    if (RuWr_me && (rd_me != '0) && (rd_me == rs))      return FWD_ME;
    else if (RuWr_wb && (rd_wb != '0) && (rd_wb == rs)) return FWD_WB;
    else                                                return FWD_RF;
  endfunction

  assign fwd_a   = (FWD_EN && rst_n) ? fwd_pick(rs1_ex) : FWD_RF;
  assign fwd_b   = (FWD_EN && rst_n) ? fwd_pick(rs2_ex) : FWD_RF;
  assign mc_done = mc_done_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (!en_fd),
    .clr_i (cnt_clr),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (redirect),
    .clr_i (cnt_clr),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default build, a 4-bit counter build
// and a no-forwarding build driven by the same stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex, rd_me, rd_wb;
  logic       rs1_used_de, rs2_used_de, RuWr_ex, is_load_ex, mc_start_ex;
  logic       RuWr_me, RuWr_wb, NextPCSrc, cnt_clr;

  always #5 clk = ~clk;

  // m = default build, c = CNT_W 4, n = FWD_EN 0
  logic        en_pc_fe_m, en_fd_m, en_de_m, flush_fd_m, flush_de_m, flush_em_m, ex_hold_m, mc_done_m;
  logic        en_pc_fe_c, en_fd_c, en_de_c, flush_fd_c, flush_de_c, flush_em_c, ex_hold_c, mc_done_c;
  logic        en_pc_fe_n, en_fd_n, en_de_n, flush_fd_n, flush_de_n, flush_em_n, ex_hold_n, mc_done_n;
  logic [1:0]  fwd_a_m, fwd_b_m, fwd_a_c, fwd_b_c, fwd_a_n, fwd_b_n;
  logic [15:0] stall_m, flush_m, stall_n, flush_n;
  logic [3:0]  stall_c, flush_c;
  logic [7:0]  ctl_m, ctl_n;

  assign ctl_m = {en_pc_fe_m, en_fd_m, en_de_m, flush_fd_m, flush_de_m, flush_em_m, ex_hold_m, mc_done_m};
  assign ctl_n = {en_pc_fe_n, en_fd_n, en_de_n, flush_fd_n, flush_de_n, flush_em_n, ex_hold_n, mc_done_n};

  pipe_hazard_ctrl dut_m (
    .clk(clk), .rst_n(rst_n), .rs1_de(rs1_de), .rs2_de(rs2_de),
    .rs1_used_de(rs1_used_de), .rs2_used_de(rs2_used_de),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .RuWr_ex(RuWr_ex),
    .is_load_ex(is_load_ex), .mc_start_ex(mc_start_ex), .rd_me(rd_me), .rd_wb(rd_wb),
    .RuWr_me(RuWr_me), .RuWr_wb(RuWr_wb), .NextPCSrc(NextPCSrc), .cnt_clr(cnt_clr),
    .en_pc_fe(en_pc_fe_m), .en_fd(en_fd_m), .en_de(en_de_m), .flush_fd(flush_fd_m),
    .flush_de(flush_de_m), .flush_em(flush_em_m), .fwd_a(fwd_a_m), .fwd_b(fwd_b_m),
    .ex_hold(ex_hold_m), .mc_done(mc_done_m), .stall_cnt(stall_m), .flush_cnt(flush_m)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .rs1_de(rs1_de), .rs2_de(rs2_de),
    .rs1_used_de(rs1_used_de), .rs2_used_de(rs2_used_de),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .RuWr_ex(RuWr_ex),
    .is_load_ex(is_load_ex), .mc_start_ex(mc_start_ex), .rd_me(rd_me), .rd_wb(rd_wb),
    .RuWr_me(RuWr_me), .RuWr_wb(RuWr_wb), .NextPCSrc(NextPCSrc), .cnt_clr(cnt_clr),
    .en_pc_fe(en_pc_fe_c), .en_fd(en_fd_c), .en_de(en_de_c), .flush_fd(flush_fd_c),
    .flush_de(flush_de_c), .flush_em(flush_em_c), .fwd_a(fwd_a_c), .fwd_b(fwd_b_c),
    .ex_hold(ex_hold_c), .mc_done(mc_done_c), .stall_cnt(stall_c), .flush_cnt(flush_c)
  );

  pipe_hazard_ctrl #(.FWD_EN(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rs1_de(rs1_de), .rs2_de(rs2_de),
    .rs1_used_de(rs1_used_de), .rs2_used_de(rs2_used_de),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .RuWr_ex(RuWr_ex),
    .is_load_ex(is_load_ex), .mc_start_ex(mc_start_ex), .rd_me(rd_me), .rd_wb(rd_wb),
    .RuWr_me(RuWr_me), .RuWr_wb(RuWr_wb), .NextPCSrc(NextPCSrc), .cnt_clr(cnt_clr),
    .en_pc_fe(en_pc_fe_n), .en_fd(en_fd_n), .en_de(en_de_n), .flush_fd(flush_fd_n),
    .flush_de(flush_de_n), .flush_em(flush_em_n), .fwd_a(fwd_a_n), .fwd_b(fwd_b_n),
    .ex_hold(ex_hold_n), .mc_done(mc_done_n), .stall_cnt(stall_n), .flush_cnt(flush_n)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rs1_de = '0; rs2_de = '0; rs1_ex = '0; rs2_ex = '0;
    rd_ex = '0; rd_me = '0; rd_wb = '0;
    rs1_used_de = 1'b0; rs2_used_de = 1'b0; RuWr_ex = 1'b0; is_load_ex = 1'b0;
    mc_start_ex = 1'b0; RuWr_me = 1'b0; RuWr_wb = 1'b0; NextPCSrc = 1'b0;
  endtask

  task automatic load_use();
    is_load_ex = 1'b1; RuWr_ex = 1'b1; rd_ex = 5'd5;
    rs1_de = 5'd5; rs1_used_de = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctl bit order: en_pc_fe en_fd en_de flush_fd flush_de flush_em ex_hold mc_done
  localparam logic [7:0] C_RST    = 8'b000_111_00;
  localparam logic [7:0] C_NORM   = 8'b111_000_00;
  localparam logic [7:0] C_LDUSE  = 8'b001_010_00;
  localparam logic [7:0] C_HOLD   = 8'b000_001_10;
  localparam logic [7:0] C_DONE   = 8'b000_001_01;
  localparam logic [7:0] C_REDIR  = 8'b111_110_00;

  initial begin
    clear_inputs();
    cnt_clr = 1'b0;
    rst_n   = 1'b0;
    RuWr_me = 1'b1; rd_me = 5'd3; rs1_ex = 5'd3;
    #3;
    check("reset_ctl", ctl_m, C_RST);
    check("reset_ctl_nofwd", ctl_n, C_RST);
    check("reset_fwd_a", fwd_a_m, 2'b00);
    check("reset_stall_cnt", stall_m, 0);
    #9 rst_n = 1'b1;
    #1;
    check("post_reset_ctl", ctl_m, C_NORM);
    check("post_reset_fwd_a", fwd_a_m, 2'b10);

    // load-use on rs1
    tick(); clear_inputs(); load_use(); #1;
    check("lduse_ctl", ctl_m, C_LDUSE);
    check("lduse_ctl_nofwd", ctl_n, C_LDUSE);
    tick(); clear_inputs(); #1;
    check("lduse_stall_cnt", stall_m, 1);
    check("lduse_released", ctl_m, C_NORM);
    tick(); load_use(); rd_ex = 5'd0; rs1_de = 5'd0; #1;
    check("lduse_x0", ctl_m, C_NORM);
    tick(); clear_inputs(); is_load_ex = 1'b1; RuWr_ex = 1'b1; rd_ex = 5'd6; rs2_de = 5'd6; #1;
    check("lduse_rs2_unused", ctl_m, C_NORM);

    // forwarding
    tick(); clear_inputs();
    RuWr_me = 1'b1; rd_me = 5'd3; RuWr_wb = 1'b1; rd_wb = 5'd3; rs1_ex = 5'd3; rs2_ex = 5'd3; #1;
    check("fwd_me_wins_a", fwd_a_m, 2'b10);
    check("fwd_me_wins_b", fwd_b_m, 2'b10);
    check("fwd_off_a", fwd_a_n, 2'b00);
    RuWr_me = 1'b0; #1;
    check("fwd_wb_a", fwd_a_m, 2'b01);
    RuWr_me = 1'b1; rd_me = 5'd0; rd_wb = 5'd0; rs1_ex = 5'd0; #1;
    check("fwd_x0_a", fwd_a_m, 2'b00);
    rd_me = 5'd7; rd_wb = 5'd4; rs1_ex = 5'd4; rs2_ex = 5'd7; #1;
    check("fwd_split_a", fwd_a_m, 2'b01);
    check("fwd_split_b", fwd_b_m, 2'b10);

    // no-forwarding build stalls on ME and non-load EX producers
    tick(); clear_inputs();
    RuWr_me = 1'b1; rd_me = 5'd9; rs2_de = 5'd9; rs2_used_de = 1'b1; rs1_ex = 5'd9; #1;
    check("me_match_fwd_ctl", ctl_m, C_NORM);
    check("me_match_fwd_a", fwd_a_m, 2'b10);
    check("me_match_nofwd_ctl", ctl_n, C_LDUSE);
    check("me_match_nofwd_a", fwd_a_n, 2'b00);
    tick(); clear_inputs(); RuWr_ex = 1'b1; rd_ex = 5'd9; rs1_de = 5'd9; rs1_used_de = 1'b1; #1;
    check("ex_alu_fwd_ctl", ctl_m, C_NORM);
    check("ex_alu_nofwd_ctl", ctl_n, C_LDUSE);
    tick(); clear_inputs(); #1;
    check("nofwd_stall_cnt", stall_n, 3);
    check("fwd_stall_cnt", stall_m, 1);
    cnt_clr = 1'b1;
    tick(); cnt_clr = 1'b0; #1;
    check("clr_stall_cnt", stall_m, 0);

    // multicycle op, redirect during BUSY ignored
    mc_start_ex = 1'b1; #1;
    check("mc_launch", ctl_m, C_HOLD);
    tick(); mc_start_ex = 1'b0; NextPCSrc = 1'b1; #1;
    check("mc_busy1_redirect_ignored", ctl_m, C_HOLD);
    tick(); NextPCSrc = 1'b0; #1;
    check("mc_busy2", ctl_m, C_HOLD);
    tick(); #1;
    check("mc_done", ctl_m, C_DONE);
    tick(); #1;
    check("mc_after", ctl_m, C_NORM);
    check("mc_stall_cnt", stall_m, 4);
    check("mc_flush_cnt", flush_m, 0);

    // redirect beats load-use
    NextPCSrc = 1'b1; load_use(); #1;
    check("redir_ctl", ctl_m, C_REDIR);
    tick(); clear_inputs(); #1;
    check("redir_flush_cnt", flush_m, 1);
    check("redir_stall_cnt", stall_m, 4);

    // saturation and clear priority
    cnt_clr = 1'b1;
    tick(); cnt_clr = 1'b0; load_use();
    repeat (20) tick();
    check("sat_stall_cnt16", stall_m, 20);
    check("sat_stall_cnt4", stall_c, 4'hF);
    cnt_clr = 1'b1;
    tick(); #1;
    check("clr_wins16", stall_m, 0);
    check("clr_wins4", stall_c, 0);
    cnt_clr = 1'b0; clear_inputs();

    // reset mid-BUSY
    tick(); mc_start_ex = 1'b1;
    tick(); mc_start_ex = 1'b0; #1;
    check("rst_busy_hold", ex_hold_m, 1'b1);
    RuWr_me = 1'b1; rd_me = 5'd3; rs1_ex = 5'd3;
    rst_n = 1'b0; #1;
    check("rst_busy_ctl", ctl_m, C_RST);
    check("rst_busy_fwd", fwd_a_m, 2'b00);
    tick();
    check("rst_busy_stall_cnt", stall_m, 0);
    rst_n = 1'b1; #1;
    check("rst_release_ctl", ctl_m, C_NORM);
    check("rst_release_fwd", fwd_a_m, 2'b10);
    tick(); #1;
    check("rst_release_idle", ctl_m, C_NORM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and stall controller for the segmented in-order RISC-V pipeline, replacing the decode-local hazard logic. Combines load-use stalls, branch-redirect flushes, operand forwarding selects for EX and a multicycle-execute hold state machine. Adds saturating stall and flush performance counters. Sits beside the FE/DE/EX/ME/WB stages and drives every inter-stage register enable and clear.

## Interface
- REG_AW, 5, register address width
- MC_LAT, 4, multicycle EX latency in cycles (≥1; 1 = no hold)
- FWD_EN, 1, 1 = forward from ME/WB; 0 = stall on RAW against EX/ME instead
- CNT_W, 16, perf counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rs1_de, rs2_de  in  REG_AW  decode source registers
- rs1_used_de, rs2_used_de  in  1  source actually read
- rs1_ex, rs2_ex, rd_ex  in  REG_AW  EX-stage register fields
- RuWr_ex, is_load_ex, mc_start_ex  in  1  EX writes RF / is load / is multicycle op
- rd_me, rd_wb  in  REG_AW  ; RuWr_me, RuWr_wb  in  1
- NextPCSrc  in  1  branch/jump taken in EX
- cnt_clr  in  1  synchronous clear of perf counters
- en_pc_fe, en_fd, en_de  out  1  PC, IF/ID, ID/EX enables
- flush_fd, flush_de, flush_em  out  1  bubble into IF/ID, ID/EX, EX/ME
- fwd_a, fwd_b  out  2  EX operand select: 00 RF, 01 WB data, 10 ME alu_out
- ex_hold  out  1  freeze multicycle unit; mc_done  out  1  last busy cycle
- stall_cnt, flush_cnt  out  CNT_W  perf counters

## Operation
- FSM: IDLE, BUSY. IDLE→BUSY when mc_start_ex=1, MC_LAT>1, NextPCSrc=0; load cnt=MC_LAT-2. BUSY: decrement; at cnt=0 assert mc_done, return to IDLE next edge.
- Priority (highest first): reset, BUSY, NextPCSrc, RAW stall, normal.
- BUSY (and IDLE cycle of mc_start_ex with MC_LAT>1): en_pc_fe=en_fd=en_de=0, ex_hold=1, flush_em=1.
- Redirect (NextPCSrc=1, not BUSY): en_pc_fe=1, flush_fd=1, flush_de=1; NextPCSrc ignored while BUSY.
- Load-use: is_load_ex & RuWr_ex & rd_ex≠0 & ((rs1_used_de & rs1_de=rd_ex) | (rs2_used_de & rs2_de=rd_ex)) → en_pc_fe=en_fd=0, flush_de=1, one cycle.
- FWD_EN=0: same stall condition extended to any RuWr_ex/RuWr_me match (not only loads); WB never stalls (RF write-before-read).
- Forwarding (FWD_EN=1): per operand, 10 if RuWr_me & rd_me≠0 & rd_me=rs; else 01 if RuWr_wb & rd_wb≠0 & rd_wb=rs; else 00. ME wins over WB. FWD_EN=0: always 00.
- Normal: all enables 1, flushes 0.
- stall_cnt += 1 on every cycle with en_fd=0; flush_cnt += 1 per redirect cycle. Both saturate at all-ones; cnt_clr wins over increment.

## Timing
- All enables/flushes/fwd/ex_hold combinational from inputs and registered state, same cycle.
- While rst_n=0: state IDLE, cnt 0, counters 0; en_*=0, flush_*=1, fwd_*=00, ex_hold=0, mc_done=0.
- Reset mid-BUSY aborts the op immediately; after release first cycle is IDLE normal.
- Multicycle op occupies EX for exactly MC_LAT cycles; ex_hold high for MC_LAT-1 of them.
- Counters update on rising edge following the qualifying cycle.

## Structure
- Package pipe_hazard_pkg: fwd_sel_e {FWD_RF=2'b00, FWD_WB=2'b01, FWD_ME=2'b10}, mc_state_e {IDLE, BUSY}.
- One sub-module: sat_counter (CNT_W, inc, clr, saturating), instanced twice.

## Test plan
- Load x5 in EX, decode uses rs1=x5 → en_pc_fe=en_fd=0, flush_de=1 one cycle, stall_cnt=1.
- RuWr_me rd_me=x3, RuWr_wb rd_wb=x3, rs1_ex=x3 → fwd_a=10; rd=x0 match → fwd_a=00.
- MC_LAT=4, mc_start_ex pulse → ex_hold 3 cycles, mc_done on 4th, stall_cnt=4, NextPCSrc during BUSY ignored.
- NextPCSrc=1 with simultaneous load-use → flush_fd=flush_de=1, en_pc_fe=1, flush_cnt=1, stall_cnt unchanged.
- CNT_W=4, 20 stall cycles → stall_cnt=15; cnt_clr → 0.
- rst_n low mid-BUSY → ex_hold=0, outputs at reset values; FWD_EN=0 with ME match → stall, fwd=00.
